// File: rtl/security_zone_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : security_pkg
// Description : Shared state codes, key-switch encodings and timing constants
//               for the multi-zone intrusion controller.
// Revision    : 1.0 - initial release
// ============================================================================
package security_pkg;

  // State codes as they appear on the STATE output
  localparam logic [2:0] STATE_DISARMED  = 3'd1;
  localparam logic [2:0] STATE_EXIT_DLY  = 3'd2;
  localparam logic [2:0] STATE_ARMED     = 3'd3;
  localparam logic [2:0] STATE_ENTRY_DLY = 3'd4;
  localparam logic [2:0] STATE_ALARM     = 3'd5;

  typedef enum logic [2:0] {
    S_DISARMED  = STATE_DISARMED,
    S_EXIT_DLY  = STATE_EXIT_DLY,
    S_ARMED     = STATE_ARMED,
    S_ENTRY_DLY = STATE_ENTRY_DLY,
    S_ALARM     = STATE_ALARM
  } state_t;

  // Key-switch encodings; the two mixed codes mean "no request"
  localparam logic [1:0] KEY_ARM    = 2'b11;
  localparam logic [1:0] KEY_DISARM = 2'b00;

  // Delay counter resolution: 10 ms ticks
  localparam int TICKS_PER_SEC = 100;

endpackage
`default_nettype wire

// File: rtl/my_disp.sv
`default_nettype none
// ============================================================================
// Module      : my_disp
// Description : Hex digit to 7-segment decoder, active-high, o_seg = {A..G}.
//               Digits above 9 blank the display.
// Revision    : 1.0 - initial release
// ============================================================================
module my_disp (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Segment lookup, bit 6 = segment A down to bit 0 = segment G
  always_comb begin
    o_seg = 7'b0000000;
    case (i_digit)
      4'd0: o_seg = 7'b1111110;
      4'd1: o_seg = 7'b0110000;
      4'd2: o_seg = 7'b1101101;
      4'd3: o_seg = 7'b1111001;
      4'd4: o_seg = 7'b0110011;
      4'd5: o_seg = 7'b1011011;
      4'd6: o_seg = 7'b1011111;
      4'd7: o_seg = 7'b1110000;
      4'd8: o_seg = 7'b1111111;
      4'd9: o_seg = 7'b1111011;
      default: o_seg = 7'b0000000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/security_zone_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider producing a one-cycle pulse every
//               TICK_DIV clocks, starting from reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divider counter wraps at TICK_DIV-1
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)           r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/security_zone_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : security_zone_ctrl
// Description : Multi-zone intrusion controller with key-switch arm/disarm,
//               exit/entry delays, instant zones, alarm timeout with re-arm,
//               latched trip memory and a two-digit multiplexed display.
// Revision    : 1.0 - initial release
// ============================================================================
module security_zone_ctrl
  import security_pkg::*;
#(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int TICK_DIV  = CLK_FREQ / 100,
  parameter int N_ZONES   = 4,
  parameter int EXIT_SEC  = 5,
  parameter int ENTRY_SEC = 5,
  parameter int ALARM_SEC = 30
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         KEY,
  input  logic [N_ZONES-1:0] ZONE,
  input  logic [N_ZONES-1:0] ZONE_EN,
  input  logic [N_ZONES-1:0] ZONE_INST,
  output logic               ALARM,
  output logic               READY,
  output logic [2:0]         STATE,
  output logic [N_ZONES-1:0] TRIPPED,
  output logic [6:0]         AN,
  output logic               CA
);

  localparam int MAX_SEC_A = (EXIT_SEC > ENTRY_SEC) ? EXIT_SEC : ENTRY_SEC;
  localparam int MAX_SEC   = (MAX_SEC_A > ALARM_SEC) ? MAX_SEC_A : ALARM_SEC;
  localparam int CNT_W     = $clog2(MAX_SEC * TICKS_PER_SEC + 1);

  localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_SEC  * TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_SEC * TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_SEC * TICKS_PER_SEC - 1);

  logic [N_ZONES-1:0] r_sync1;
  logic [N_ZONES-1:0] r_sync2;
  logic [N_ZONES-1:0] w_zs;
  logic [N_ZONES-1:0] r_trip;
  logic [N_ZONES-1:0] w_trip_nxt;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_last;
  logic               w_timed;
  logic               w_expire;
  logic               w_tick;
  logic               r_ca;
  logic [3:0]         w_low_idx;
  logic [3:0]         w_digit;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .o_tick  (w_tick)
  );

  // Two-flop synchroniser for the asynchronous sensor lines
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ZONE;
      r_sync2 <= r_sync1;
    end
  end

  assign w_zs  = r_sync2 & ZONE_EN;
  assign READY = ~|w_zs;

  // Select the terminal count of the delay belonging to the current state
  always_comb begin
    w_last  = '0;
    w_timed = 1'b0;
    case (r_state)
      S_EXIT_DLY:  begin w_last = EXIT_LAST;  w_timed = 1'b1; end
      S_ENTRY_DLY: begin w_last = ENTRY_LAST; w_timed = 1'b1; end
      S_ALARM:     begin w_last = ALARM_LAST; w_timed = 1'b1; end
      default:     begin w_last = '0;         w_timed = 1'b0; end
    endcase
  end

  assign w_expire = w_tick && w_timed && (r_cnt == w_last);

  // Next-state and trip-memory logic; a disarm request overrides everything,
  // including a same-cycle expiry or zone trip, and leaves TRIPPED untouched
  always_comb begin
    w_state_nxt = r_state;
    w_trip_nxt  = r_trip;
    if (KEY == KEY_DISARM) begin
      w_state_nxt = S_DISARMED;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (KEY == KEY_ARM && READY) begin
            w_state_nxt = S_EXIT_DLY;
            w_trip_nxt  = '0;
          end
        end
        S_EXIT_DLY: begin
          if (w_expire) w_state_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (|(w_zs & ZONE_INST)) begin
            w_state_nxt = S_ALARM;
            w_trip_nxt  = r_trip | w_zs;
          end else if (|w_zs) begin
            w_state_nxt = S_ENTRY_DLY;
            w_trip_nxt  = r_trip | w_zs;
          end
        end
        S_ENTRY_DLY: begin
          w_trip_nxt = r_trip | w_zs;
          if (|(w_zs & ZONE_INST) || w_expire) w_state_nxt = S_ALARM;
        end
        S_ALARM: begin
          w_trip_nxt = r_trip | w_zs;
          if (w_expire) w_state_nxt = S_ARMED;
        end
        default: begin
          w_state_nxt = S_DISARMED;
        end
      endcase
    end
  end

  // State and trip-memory registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_DISARMED;
      r_trip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_trip  <= w_trip_nxt;
    end
  end

  // Delay counter: restarts on every state change, advances on ticks in timed states
  always_ff @(posedge CLK) begin
    if (!RST)                         r_cnt <= '0;
    else if (w_state_nxt != r_state)  r_cnt <= '0;
    else if (w_tick && w_timed)       r_cnt <= r_cnt + CNT_W'(1);
  end

  // Digit select flips once per tick
  always_ff @(posedge CLK) begin
    if (!RST)        r_ca <= 1'b0;
    else if (w_tick) r_ca <= ~r_ca;
  end

  // One-based index of the lowest latched zone, zero when none latched
  always_comb begin
    w_low_idx = 4'd0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      if (r_trip[i]) w_low_idx = 4'(i + 1);
    end
  end

  assign w_digit = r_ca ? w_low_idx : {1'b0, r_state};

  my_disp u_disp (
    .i_digit (w_digit),
    .o_seg   (AN)
  );

  assign ALARM   = (r_state == S_ALARM);
  assign STATE   = r_state;
  assign TRIPPED = r_trip;
  assign CA      = r_ca;

endmodule
`default_nettype wire

// File: doc/security_zone_ctrl.md
# security_zone_ctrl

Multi-zone intrusion controller: N synchronised sensor zones, key-switch arm/disarm, exit and entry delays, instant zones, alarm timeout with re-arm, latched trip memory and a two-digit multiplexed 7-segment status display. It replaces the single door/window security FSM in the lab design and sits between board switches/buttons and the LED and 7-segment pins.

## Interface
- CLK_FREQ, 125_000_000: input clock frequency, Hz.
- TICK_DIV, CLK_FREQ/100: CLK cycles per 10 ms tick; override small for simulation.
- N_ZONES, 4: sensor zone count, legal range 1..9.
- EXIT_SEC, 5: exit delay, seconds.
- ENTRY_SEC, 5: entry delay, seconds.
- ALARM_SEC, 30: alarm duration before auto re-arm, seconds.

- CLK  in  1  system clock; the only clock.
- RST  in  1  reset; synchronous, active-low.
- KEY  in  2  key switch: 2'b11 = arm request, 2'b00 = disarm, 01/10 = no request.
- ZONE  in  N_ZONES  raw sensor lines, 1 = open/violated; asynchronous.
- ZONE_EN  in  N_ZONES  zone enable mask; static during armed states.
- ZONE_INST  in  N_ZONES  1 = instant zone (no entry delay).
- ALARM  out  1  siren/LED, high in ALARM state.
- READY  out  1  high when no enabled synchronised zone is open.
- STATE  out  3  encoded state (package constants).
- TRIPPED  out  N_ZONES  latched zones that caused entry delay or alarm.
- AN  out  7  segment pattern A..G.
- CA  out  1  digit select.

## Operation
- ZONE passes a 2-flop synchroniser; zs = sync & ZONE_EN used everywhere below.
- States/codes: DISARMED 1, EXIT_DLY 2, ARMED 3, ENTRY_DLY 4, ALARM 5.
- Global rule: KEY == 00 in any state → DISARMED next cycle; highest priority.
- DISARMED: KEY == 11 and READY → EXIT_DLY, TRIPPED cleared. KEY == 11 and not READY → stay.
- EXIT_DLY: zones ignored; delay counter expires → ARMED.
- ARMED: any zs & ZONE_INST → ALARM; else any zs → ENTRY_DLY; triggering bits OR-ed into TRIPPED.
- ENTRY_DLY: further zs bits OR into TRIPPED; any zs & ZONE_INST → ALARM immediately; counter expiry → ALARM.
- ALARM: ALARM = 1; zs bits keep OR-ing into TRIPPED; counter expiry → ARMED (TRIPPED retained).
- Invalid KEY (01/10) is no request in all states.
- Delay counter: counts 10 ms ticks, zeroed on every state entry; expiry when count == SEC*100−1 on a tick.
- TRIPPED cleared only on DISARMED→EXIT_DLY and by reset.
- Display: CA toggles every tick; CA = 0 shows STATE code, CA = 1 shows index+1 of lowest set TRIPPED bit (0 if none), via my_disp.

## Timing
- Reset (RST low at a CLK edge): STATE = DISARMED, ALARM 0, TRIPPED 0, CA 0, tick and delay counters 0, synchroniser flops 0. Reset mid-delay aborts immediately.
- ZONE edge at cycle t → zs at t+2 → state/TRIPPED change visible at t+3.
- KEY change at t → state change visible at t+1 (KEY assumed debounced upstream).
- Outputs ALARM, STATE, READY, TRIPPED are registered or decoded from registered state only; no combinational path from KEY/ZONE.
- Tick pulse: one cycle every TICK_DIV cycles, free-running from reset; delays therefore accurate to −1 tick.
- Simultaneous KEY 00 and counter expiry or zone trip: disarm wins.
- Simultaneous instant and delayed zone trip in ARMED: ALARM, both bits latched.

## Structure
- Package security_pkg: state codes (3-bit localparams), KEY_ARM 2'b11, KEY_DISARM 2'b00, TICKS_PER_SEC 100.
- Sub-module tick_gen: parameter TICK_DIV, outputs 1-cycle tick; reused by display and delay counter.
- Existing my_disp instantiated for segment decode; synchroniser and FSM inline.

## Test plan
- TICK_DIV=4, EXIT_SEC=1: reset, KEY=11 with zones closed → EXIT_DLY; ARMED reached at 400±4 cycles; STATE 2 then 3.
- Armed, ZONE[1] (delayed) high for 1 cycle → ENTRY_DLY at t+3, TRIPPED=0010; KEY=00 before expiry → DISARMED, ALARM never 1, TRIPPED stays 0010, display digit1 = 2.
- Armed, ZONE_INST[3]=1, ZONE[3] pulse → ALARM at t+3, TRIPPED=1000; ALARM_SEC=1 → back to ARMED after 400±4 cycles, ALARM 0.
- ZONE[0] open, ZONE_EN[0]=1, KEY=11 → stays DISARMED, READY 0; ZONE_EN[0]=0 → READY 1, arming proceeds.
- ENTRY_DLY with KEY=00 on the expiry cycle → DISARMED, ALARM stays 0.
- RST low during ALARM → next cycle all outputs at reset values, CA 0.
